cpu_clk_gen: RTL and testbench
==============================

# cpu_clk_gen

Parametrised CPU clock generator between the board clock and the pipeline CPU. Keeps a free-running cycle counter for display and seven-segment scanning, and produces a glitch-free registered CPU clock. The CPU clock has four modes: continuous run at a programmable divide ratio, debounced single-step from a push button, burst of N cycles, and halt. Mode changes take effect only at period boundaries, so the CPU never sees a truncated high phase.

## Interface
- CNT_W, 32, width of free-running counter `clkdiv`
- DIV_W, 8, width of `div_sel`
- DEB_CYCLES, 16, consecutive stable samples required to accept a button level (≥2)
- BURST_W, 16, width of `burst_len` and the remaining-cycles counter
- clk  in  1  board clock; all logic on its rising edge
- rst  in  1  reset, asynchronous, active-high
- mode  in  2  00 RUN, 01 STEP, 10 BURST, 11 HALT
- div_sel  in  DIV_W  half-period length minus one, in clk cycles
- hand_btn  in  1  raw push button, asynchronous, bouncy
- burst_len  in  BURST_W  number of CPU periods per burst
- burst_go  in  1  single-cycle burst launch request
- clkdiv  out  CNT_W  free-running counter
- clk_cpu  out  1  CPU clock, registered
- cpu_tick  out  1  one-clk pulse in the cycle `clk_cpu` rises
- busy  out  1  generator not IDLE

## Operation
- Reset values: `clkdiv`=0, `clk_cpu`=0, `cpu_tick`=0, `busy`=0, state IDLE, step_pend=0, debounced level=0, debounce count=0, remaining=0.
- `clkdiv` increments by 1 every clk and wraps from all-ones to 0. It is independent of mode.
- Phase counter `hp_cnt`:
  - `div_sel` is latched into div_q on every transition into HIGH or LOW.
  - A phase lasts div_q+1 clk cycles, so a full period is 2·(div_sel+1) clk cycles.
  - A `div_sel` change mid-phase affects only the next phase.
- State machine:
  - IDLE: `clk_cpu`=0; mode_q <= `mode` every cycle.
  - IDLE → HIGH when any of:
    - mode=RUN;
    - mode=STEP and step_pend=1 (consumes step_pend, remaining=1);
    - mode=BURST and `burst_go`=1 and `burst_len`≠0 (remaining=`burst_len`).
  - HIGH: `clk_cpu`=1 for div_q+1 cycles, then → LOW.
  - LOW: `clk_cpu`=0 for div_q+1 cycles, then:
    - mode_q=RUN and `mode`=RUN → HIGH.
    - mode_q=BURST, remaining>1 and `mode`=BURST → HIGH, remaining−1.
    - Otherwise → IDLE.
    - If HALT or any mode change is seen at the end of LOW, the state goes to IDLE; the current period always completes.
- `burst_go` is ignored unless state=IDLE and mode=BURST. `burst_len`=0 launches nothing.
- Step input path:
  - `hand_btn` passes through a 2-FF synchroniser.
  - The debounced level updates only after DEB_CYCLES consecutive equal synchronised samples differing from it.
  - A debounced 0→1 edge sets step_pend. step_pend holds at most one press; further presses while pending are dropped.
  - step_pend is cleared whenever mode≠STEP.
- `cpu_tick` is registered and high in exactly the cycle `clk_cpu` goes 0→1.
- `busy` = (state≠IDLE).

## Timing
- From IDLE, the launch condition is sampled at edge n; `clk_cpu`=1 and `cpu_tick`=1 after edge n.
- RUN with `div_sel`=0 gives `clk_cpu` = clk/2 (1,0,1,0…). `div_sel`=3 gives clk/8 with 50 % duty.
- A continuous RUN or BURST has no gap between LOW and the next HIGH.
- Re-entering from IDLE adds one extra low cycle.
- Step latency: button stable high → step_pend set takes 2 (sync) + DEB_CYCLES clk cycles. `clk_cpu` rises one cycle later if the state is IDLE.
- rst asserted mid-phase forces all outputs to reset values immediately, asynchronously. The first launch can occur at the first clk edge after rst deasserts.

## Test plan
- Reset, then RUN with `div_sel`=0 for 20 clk → `clk_cpu` toggles every clk, 10 `cpu_tick` pulses, `clkdiv`=20.
- RUN with `div_sel`=3; switch to HALT mid-HIGH → HIGH completes 4 cycles, LOW completes 4 cycles, then IDLE with `clk_cpu`=0 and `busy`=0. No high phase shorter than 4.
- STEP with DEB_CYCLES=4, `div_sel`=1; press `hand_btn` with 3-cycle bounce glitches, then hold → exactly one period (2 high, 2 low), one `cpu_tick`. A second press during that period yields exactly one more period.
- BURST with `burst_len`=5, `div_sel`=2; pulse `burst_go`, pulse it again mid-burst → exactly 5 periods of 6 clk, second go ignored. `burst_len`=0 plus go → no activity.
- RUN with `div_sel` changed 1→4 mid-HIGH → current phase keeps length 2, next LOW lasts 5.
- Force `clkdiv` to all-ones via a long run or force → wraps to 0. Assert rst mid-HIGH → `clk_cpu`=0 and `cpu_tick`=0 immediately.

Source files
------------

// File: rtl/cpu_clk_gen.sv
// CPU clock generator: free-running board-clock counter plus a registered CPU clock
// with RUN / STEP / BURST / HALT modes that only change at CPU-period boundaries.
//
// state | meaning
// IDLE  | clk_cpu low, waiting for a launch condition; mode_q tracks mode
// HIGH  | clk_cpu high for div_q+1 clk cycles
// LOW   | clk_cpu low for div_q+1 clk cycles, then continue or return to IDLE
module cpu_clk_gen #(
  parameter int CNT_W      = 32,
  parameter int DIV_W      = 8,
  parameter int DEB_CYCLES = 16,
  parameter int BURST_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   div_sel,
  input  logic               hand_btn,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               burst_go,
  output logic [CNT_W-1:0]   clkdiv,
  output logic               clk_cpu,
  output logic               cpu_tick,
  output logic               busy
);

  localparam logic [1:0] M_RUN   = 2'b00;
  localparam logic [1:0] M_STEP  = 2'b01;
  localparam logic [1:0] M_BURST = 2'b10;
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t             state;
  logic [DIV_W-1:0]   hp_cnt;
  logic [1:0]         mode_q;
  logic [BURST_W-1:0] remaining;
  logic               step_pend;
  logic               btn_s1, btn_s2;
  logic               deb_lvl;
  logic [DEB_W-1:0]   deb_cnt;
  logic               deb_rise;
  logic               launch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) clkdiv <= '0;
    else     clkdiv <= clkdiv + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= hand_btn;
      btn_s2 <= btn_s1;
    end
  end

  // The debounced level flips on the DEB_CYCLES-th consecutive differing sample.
  assign deb_rise = btn_s2 && !deb_lvl && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_lvl <= 1'b0;
      deb_cnt <= '0;
    end else if (btn_s2 == deb_lvl) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_lvl <= btn_s2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  always_comb begin
    launch = 1'b0;
    unique case (mode)
      M_RUN:   launch = 1'b1;
      M_STEP:  launch = step_pend;
      M_BURST: launch = burst_go && (burst_len != '0);
      default: launch = 1'b0;
    endcase
  end

  // hp_cnt is loaded with div_sel at every phase entry and counts down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hp_cnt    <= '0;
      mode_q    <= '0;
      remaining <= '0;
      step_pend <= 1'b0;
      clk_cpu   <= 1'b0;
      cpu_tick  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cpu_tick <= 1'b0;
      if (mode != M_STEP) step_pend <= 1'b0;
      else if (deb_rise)  step_pend <= 1'b1;

      case (state)
        IDLE: begin
          mode_q  <= mode;
          clk_cpu <= 1'b0;
          if (launch) begin
            state    <= HIGH;
            clk_cpu  <= 1'b1;
            cpu_tick <= 1'b1;
            busy     <= 1'b1;
            hp_cnt   <= div_sel;
            if (mode == M_STEP) begin
              step_pend <= 1'b0;
              remaining <= BURST_W'(1);
            end else if (mode == M_BURST) begin
              remaining <= burst_len;
            end
          end
        end
        HIGH: begin
          if (hp_cnt == '0) begin
            state   <= LOW;
            clk_cpu <= 1'b0;
            hp_cnt  <= div_sel;
          end else begin
            hp_cnt <= hp_cnt - DIV_W'(1);
          end
        end
        LOW: begin
          if (hp_cnt == '0) begin
            if (mode_q == M_RUN && mode == M_RUN) begin
              state    <= HIGH;
              clk_cpu  <= 1'b1;
              cpu_tick <= 1'b1;
              hp_cnt   <= div_sel;
            end else if (mode_q == M_BURST && mode == M_BURST &&
                         remaining > BURST_W'(1)) begin
              state     <= HIGH;
              clk_cpu   <= 1'b1;
              cpu_tick  <= 1'b1;
              hp_cnt    <= div_sel;
              remaining <= remaining - BURST_W'(1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            hp_cnt <= hp_cnt - DIV_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          clk_cpu <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_clk_gen.sv
// Directed bench for cpu_clk_gen: reset, RUN, HALT mid-phase, debounced STEP,
// BURST, divider change, counter wrap and asynchronous reset.
module tb_cpu_clk_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'b11;
  logic [7:0]  div_sel = '0;
  logic        hand_btn = 1'b0;
  logic [15:0] burst_len = '0;
  logic        burst_go = 1'b0;
  logic [7:0]  clkdiv;
  logic        clk_cpu;
  logic        cpu_tick;
  logic        busy;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] RUN = 2'b00, STEP = 2'b01, BURST = 2'b10, HALT = 2'b11;

  cpu_clk_gen #(.CNT_W(8), .DIV_W(8), .DEB_CYCLES(4), .BURST_W(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .div_sel(div_sel), .hand_btn(hand_btn),
    .burst_len(burst_len), .burst_go(burst_go), .clkdiv(clkdiv),
    .clk_cpu(clk_cpu), .cpu_tick(cpu_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    mode = HALT;
    div_sel = '0;
    hand_btn = 1'b0;
    burst_len = '0;
    burst_go = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    tests++;
    if ({clkdiv, clk_cpu, cpu_tick, busy} !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs: got clkdiv=%0d clk_cpu=%b tick=%b busy=%b want all 0",
               clkdiv, clk_cpu, cpu_tick, busy);
    end
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    tests++;
    if (clkdiv !== 8'd3 || clk_cpu !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_halt_idle: got clkdiv=%0d clk_cpu=%b busy=%b want 3 0 0",
               clkdiv, clk_cpu, busy);
    end
  endtask

  task automatic test_run_div0;
    int ticks;
    logic exp_v;
    ticks = 0;
    do_reset();
    mode = RUN;
    div_sel = 8'd0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp_v = e[0];
      tests++;
      if (clk_cpu !== exp_v || cpu_tick !== exp_v) begin
        fails++;
        $display("FAIL run_div0 edge %0d: got clk_cpu=%b tick=%b want %b", e, clk_cpu, cpu_tick, exp_v);
      end
      if (cpu_tick === 1'b1) ticks++;
    end
    tests++;
    if (ticks != 10) begin
      fails++;
      $display("FAIL run_div0_ticks: got %0d want 10", ticks);
    end
    tests++;
    if (clkdiv !== 8'd20) begin
      fails++;
      $display("FAIL run_div0_clkdiv: got %0d want 20", clkdiv);
    end
  endtask

  task automatic test_halt_mid_high;
    logic exp_c, exp_b, exp_t;
    do_reset();
    mode = RUN;
    div_sel = 8'd3;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_c = (e <= 4);
      exp_b = (e <= 8);
      exp_t = (e == 1);
      tests++;
      if (clk_cpu !== exp_c || busy !== exp_b || cpu_tick !== exp_t) begin
        fails++;
        $display("FAIL halt_mid_high edge %0d: got clk_cpu=%b busy=%b tick=%b want %b %b %b",
                 e, clk_cpu, busy, cpu_tick, exp_c, exp_b, exp_t);
      end
      if (e == 2) mode = HALT;
    end
  endtask

  task automatic test_step;
    int ticks;
    logic exp_c, exp_t;
    ticks = 0;
    do_reset();
    mode = STEP;
    div_sel = 8'd1;
    for (int j = 1; j <= 34; j++) begin
      // short bounces, a real press, a release, then a second press mid-period
      hand_btn = (j <= 3) || (j == 5) || (j >= 7 && j <= 9) ||
                 (j >= 11 && j <= 14) || (j >= 19);
      tick();
      exp_c = (j == 17) || (j == 18) || (j == 25) || (j == 26);
      exp_t = (j == 17) || (j == 25);
      tests++;
      if (clk_cpu !== exp_c || cpu_tick !== exp_t) begin
        fails++;
        $display("FAIL step edge %0d: got clk_cpu=%b tick=%b want %b %b",
                 j, clk_cpu, cpu_tick, exp_c, exp_t);
      end
      if (cpu_tick === 1'b1) ticks++;
    end
    tests++;
    if (ticks != 2) begin
      fails++;
      $display("FAIL step_ticks: got %0d want 2", ticks);
    end
  endtask

  task automatic test_burst;
    logic exp_c, exp_t, exp_b;
    do_reset();
    mode = BURST;
    div_sel = 8'd2;
    burst_len = 16'd5;
    for (int e = 1; e <= 40; e++) begin
      burst_go = (e == 1) || (e == 10);
      tick();
      exp_c = (e <= 30) && (((e - 1) % 6) < 3);
      exp_t = (e <= 30) && (((e - 1) % 6) == 0);
      exp_b = (e <= 30);
      tests++;
      if (clk_cpu !== exp_c || cpu_tick !== exp_t || busy !== exp_b) begin
        fails++;
        $display("FAIL burst edge %0d: got clk_cpu=%b tick=%b busy=%b want %b %b %b",
                 e, clk_cpu, cpu_tick, busy, exp_c, exp_t, exp_b);
      end
    end
    burst_go = 1'b0;
    burst_len = 16'd0;
    for (int e = 1; e <= 10; e++) begin
      burst_go = (e == 1);
      tick();
      tests++;
      if (clk_cpu !== 1'b0 || busy !== 1'b0 || cpu_tick !== 1'b0) begin
        fails++;
        $display("FAIL burst_len0 edge %0d: got clk_cpu=%b busy=%b tick=%b want 0 0 0",
                 e, clk_cpu, busy, cpu_tick);
      end
    end
    burst_go = 1'b0;
  endtask

  task automatic test_div_change;
    logic exp_c, exp_t;
    do_reset();
    mode = RUN;
    div_sel = 8'd1;
    for (int e = 1; e <= 13; e++) begin
      tick();
      exp_c = (e <= 2) || (e >= 8 && e <= 12);
      exp_t = (e == 1) || (e == 8);
      tests++;
      if (clk_cpu !== exp_c || cpu_tick !== exp_t) begin
        fails++;
        $display("FAIL div_change edge %0d: got clk_cpu=%b tick=%b want %b %b",
                 e, clk_cpu, cpu_tick, exp_c, exp_t);
      end
      if (e == 1) div_sel = 8'd4;
    end
  endtask

  task automatic test_wrap_and_async_reset;
    do_reset();
    for (int i = 0; i < 255; i++) tick();
    tests++;
    if (clkdiv !== 8'd255) begin
      fails++;
      $display("FAIL clkdiv_allones: got %0d want 255", clkdiv);
    end
    tick();
    tests++;
    if (clkdiv !== 8'd0) begin
      fails++;
      $display("FAIL clkdiv_wrap: got %0d want 0", clkdiv);
    end
    mode = RUN;
    div_sel = 8'd3;
    tick();
    tests++;
    if (clk_cpu !== 1'b1 || cpu_tick !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_high: got clk_cpu=%b tick=%b busy=%b want 1 1 1",
               clk_cpu, cpu_tick, busy);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (clk_cpu !== 1'b0 || cpu_tick !== 1'b0 || busy !== 1'b0 || clkdiv !== 8'd0) begin
      fails++;
      $display("FAIL async_reset: got clk_cpu=%b tick=%b busy=%b clkdiv=%0d want 0 0 0 0",
               clk_cpu, cpu_tick, busy, clkdiv);
    end
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (clk_cpu !== 1'b1 || cpu_tick !== 1'b1 || clkdiv !== 8'd1) begin
      fails++;
      $display("FAIL first_launch_after_reset: got clk_cpu=%b tick=%b clkdiv=%0d want 1 1 1",
               clk_cpu, cpu_tick, clkdiv);
    end
  endtask

  initial begin
    test_reset();
    test_run_div0();
    test_halt_mid_high();
    test_step();
    test_burst();
    test_div_change();
    test_wrap_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
